// File: rtl/dac_spi_tx.sv
// Serial DAC driver: accepts 16-bit samples over valid/ready and shifts each one out
// as a 24-bit SPI frame (command byte + sample) with programmable SCLK rate and frame gap.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned IDLE_CYC  = 4,
    parameter logic [7:0]  CMD       = 8'h00,
    parameter bit          TWOS_COMP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        dac_sync_n,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        frame_done,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [7:0]  HALF_TC  = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_TC   = 8'(IDLE_CYC - 1);
    localparam logic [15:0] MSB_FLIP = TWOS_COMP ? 16'h8000 : 16'h0000;

    state_t      state;
    logic [22:0] shift_word;
    logic [7:0]  half_cnt;
    logic [7:0]  gap_cnt;
    logic [4:0]  bit_cnt;
    logic [23:0] accept_word;

    assign accept_word = {CMD, sample_in ^ MSB_FLIP};

    // Bit 23 goes straight to dac_din on accept; shift_word holds the bits still to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shift_word   <= '0;
            half_cnt     <= '0;
            gap_cnt      <= '0;
            bit_cnt      <= '0;
            sample_ready <= 1'b1;
            dac_sync_n   <= 1'b1;
            dac_sclk     <= 1'b1;
            dac_din      <= 1'b0;
            frame_done   <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;

            if (sample_valid && !sample_ready && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            unique case (state)
                IDLE: begin
                    if (sample_valid && sample_ready) begin
                        state        <= SHIFT;
                        shift_word   <= accept_word[22:0];
                        dac_din      <= accept_word[23];
                        dac_sync_n   <= 1'b0;
                        dac_sclk     <= 1'b1;
                        half_cnt     <= '0;
                        bit_cnt      <= '0;
                        sample_ready <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (half_cnt == HALF_TC) begin
                        half_cnt <= '0;
                        if (dac_sclk) begin
                            dac_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt + 5'd1;
                        end else if (bit_cnt == 5'd24) begin
                            // Final low half-period elapsed: close the frame instead of rising.
                            state      <= GAP;
                            dac_sclk   <= 1'b1;
                            dac_sync_n <= 1'b1;
                            dac_din    <= 1'b0;
                            frame_done <= 1'b1;
                            bit_cnt    <= '0;
                            gap_cnt    <= '0;
                        end else begin
                            dac_sclk   <= 1'b1;
                            dac_din    <= shift_word[22];
                            shift_word <= {shift_word[21:0], 1'b0};
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_TC) begin
                        state        <= IDLE;
                        sample_ready <= 1'b1;
                        gap_cnt      <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (default rates, and fast/two's-complement with CMD 0x10)
// feed a scoreboard; a per-instance SPI capture model checks every frame against it.
`timescale 1ns/1ps
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] smp_a, smp_b;
    logic        vld_a, vld_b;
    logic        rdy_a, rdy_b, sync_a, sync_b, sclk_a, sclk_b, din_a, din_b, done_a, done_b;
    logic [7:0]  drop_a, drop_b;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] q_a[$];
    logic [23:0] q_b[$];
    int exp_frames[2];
    int frames[2];
    int low_cnt[2];
    int falls[2];
    int model_drop[2];
    logic [23:0] cap[2];
    logic prev_sclk[2];
    int n;

    dac_spi_tx u_a (
        .clk(clk), .rst_n(rst_n), .sample_in(smp_a), .sample_valid(vld_a),
        .sample_ready(rdy_a), .dac_sync_n(sync_a), .dac_sclk(sclk_a), .dac_din(din_a),
        .frame_done(done_a), .drop_cnt(drop_a)
    );

    dac_spi_tx #(.CLK_DIV(1), .IDLE_CYC(1), .CMD(8'h10), .TWOS_COMP(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .sample_in(smp_b), .sample_valid(vld_b),
        .sample_ready(rdy_b), .dac_sync_n(sync_b), .dac_sclk(sclk_b), .dac_din(din_b),
        .frame_done(done_b), .drop_cnt(drop_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int divOf(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int periodOf(input int d);
        return 48 * divOf(d) + ((d == 0) ? 4 : 1) + 1;
    endfunction

    // Instance A sends the sample as-is with CMD 0x00; B flips the MSB and uses CMD 0x10.
    function automatic logic [23:0] frameOf(input int d, input logic [15:0] v);
        if (d == 0) return {8'h00, v};
        return {8'h10, ~v[15], v[14:0]};
    endfunction

    function automatic logic readyOf(input int d);
        return (d == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic doneOf(input int d);
        return (d == 0) ? done_a : done_b;
    endfunction

    function automatic logic [12:0] outsOf(input int d);
        if (d == 0) return {rdy_a, sync_a, sclk_a, din_a, done_a, drop_a};
        return {rdy_b, sync_b, sclk_b, din_b, done_b, drop_b};
    endfunction

    task automatic setInputs(input int d, input logic v, input logic [15:0] s);
        if (d == 0) begin vld_a = v; smp_a = s; end
        else begin vld_b = v; smp_b = s; end
    endtask

    task automatic pushExp(input int d, input logic [15:0] v);
        exp_frames[d]++;
        if (d == 0) q_a.push_back(frameOf(0, v));
        else q_b.push_back(frameOf(1, v));
    endtask

    task automatic waitReady(input int d);
        int k = 0;
        while (!readyOf(d) && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 1000) checkOutput("ready_timeout", readyOf(d), 1);
    endtask

    task automatic waitFor(input int d, input bit want_done, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!(want_done ? doneOf(d) : readyOf(d)) && cnt < 1000);
    endtask

    task automatic applyStimulus(input int d, input logic [15:0] v);
        waitReady(d);
        setInputs(d, 1'b1, v);
        pushExp(d, v);
        @(posedge clk); #1;
        setInputs(d, 1'b0, 16'hDEAD);
    endtask

    // Valid held for cnt cycles; accepts expected every frame period starting at cycle 0.
    task automatic holdValid(input int d, input int cnt, input bit step,
                             input logic [15:0] a, input logic [15:0] b);
        int p = periodOf(d);
        int acc = 0;
        logic [15:0] v;
        waitReady(d);
        for (int i = 0; i < cnt; i++) begin
            v = step ? a + 16'(i) : ((i < p) ? a : b);
            setInputs(d, 1'b1, v);
            if (i % p == 0) begin
                pushExp(d, v);
                acc++;
            end
            @(posedge clk); #1;
        end
        setInputs(d, 1'b0, 16'h0000);
        model_drop[d] = (model_drop[d] + cnt - acc > 255) ? 255 : model_drop[d] + cnt - acc;
    endtask

    task automatic checkIdle(input int d);
        string pre = (d == 0) ? "A." : "B.";
        logic [12:0] o = outsOf(d);
        checkOutput({pre, "ready"}, o[12], 1);
        checkOutput({pre, "sync_n"}, o[11], 1);
        checkOutput({pre, "sclk"}, o[10], 1);
        checkOutput({pre, "din"}, o[9], 0);
        checkOutput({pre, "frame_done"}, o[8], 0);
        checkOutput({pre, "drop_cnt"}, o[7:0], model_drop[d]);
    endtask

    task automatic observe(input int d, input logic s, input logic c, input logic di, input logic fd);
        string pre = (d == 0) ? "A." : "B.";
        logic [23:0] exp;
        int sz;
        if (!rst_n) begin
            low_cnt[d] = 0; falls[d] = 0; cap[d] = '0; prev_sclk[d] = 1'b1;
            return;
        end
        if (!s) begin
            low_cnt[d]++;
            if (prev_sclk[d] && !c) begin
                cap[d] = {cap[d][22:0], di};
                falls[d]++;
            end
        end
        if (fd) begin
            frames[d]++;
            sz = (d == 0) ? q_a.size() : q_b.size();
            checkOutput({pre, "frame_expected"}, (sz > 0), 1);
            if (sz > 0) begin
                exp = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                checkOutput({pre, "frame"}, cap[d], exp);
            end
            checkOutput({pre, "falls"}, falls[d], 24);
            checkOutput({pre, "sync_low"}, low_cnt[d], 48 * divOf(d));
            checkOutput({pre, "sync_at_done"}, s, 1);
            checkOutput({pre, "din_at_done"}, di, 0);
            low_cnt[d] = 0; falls[d] = 0; cap[d] = '0;
        end
        prev_sclk[d] = c;
    endtask

    always @(negedge clk) begin
        observe(0, sync_a, sclk_a, din_a, done_a);
        observe(1, sync_b, sclk_b, din_b, done_b);
    end

    initial begin
        rst_n = 1'b0;
        setInputs(0, 1'b0, 16'h0000);
        setInputs(1, 1'b0, 16'h0000);
        for (int d = 0; d < 2; d++) begin
            model_drop[d] = 0; exp_frames[d] = 0; frames[d] = 0;
        end
        #12;
        checkIdle(0);
        checkIdle(1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] mid-scale frame at default rates");
        applyStimulus(0, 16'h8000);
        waitFor(0, 1'b1, n);
        checkOutput("A.done_latency", n, 96);
        waitFor(0, 1'b0, n);
        checkOutput("A.ready_after_done", n, 4);
        checkIdle(0);

        $display("[TB] back-to-back samples with valid held");
        holdValid(0, 102, 1'b0, 16'hFFFF, 16'h0000);
        waitReady(0);
        checkOutput("A.drop_pair", drop_a, model_drop[0]);
        holdValid(1, 51, 1'b0, 16'hFFFF, 16'h0000);
        waitReady(1);
        checkOutput("B.drop_pair", drop_b, model_drop[1]);

        $display("[TB] fastest SCLK, single sample");
        applyStimulus(1, 16'hA5A5);
        waitFor(1, 1'b1, n);
        checkOutput("B.done_latency", n, 48);
        waitFor(1, 1'b0, n);
        checkOutput("B.ready_after_done", n, 1);

        $display("[TB] stepping input with valid held, drop saturation");
        holdValid(0, 300, 1'b1, 16'h0100, 16'h0000);
        waitReady(0);
        checkOutput("A.drop_sat", drop_a, model_drop[0]);
        holdValid(1, 300, 1'b1, 16'hF000, 16'h0000);
        waitReady(1);
        checkOutput("B.drop_sat", drop_b, model_drop[1]);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 16'h5555);
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_drop[0] = 0;
        model_drop[1] = 0;
        checkIdle(0);
        checkIdle(1);
        q_a.delete();
        exp_frames[0]--;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, 16'h1234);
        waitFor(0, 1'b1, n);
        checkOutput("A.done_after_reset", n, 96);
        waitReady(0);

        $display("[TB] triangle sweep");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, (i < 8) ? 16'(i * 8192) : 16'(65535 - (i - 8) * 8192));
        end
        waitReady(0);
        checkOutput("A.drop_triangle", drop_a, model_drop[0]);

        repeat (4) @(posedge clk);
        checkOutput("A.queue_empty", q_a.size(), 0);
        checkOutput("B.queue_empty", q_b.size(), 0);
        checkOutput("A.frame_count", frames[0], exp_frames[0]);
        checkOutput("B.frame_count", frames[1], exp_frames[1]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC driver that consumes the 16-bit offset-binary sample stream produced by the waveform generators (triangle, sine, square, sawtooth; mid-scale = 32768) and shifts each accepted sample to an external 24-bit-frame SPI DAC (8 command bits + 16 data bits, DAC8551-class). It sits directly downstream of the waveform mux. It provides a valid/ready handshake upstream, latches each sample, and generates SYNC_N/SCLK/DIN with programmable SCLK rate and inter-frame gap.

## Interface
- CLK_DIV, 2: SCLK half-period in clk cycles; legal range 1..255.
- IDLE_CYC, 4: clk cycles SYNC_N held high between frames; legal range 1..255.
- CMD, 8'h00: command byte sent as frame bits 23..16.
- TWOS_COMP, 0: when 1, sample MSB is inverted before transmission (offset-binary to two's complement).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_in  in  16  sample word from waveform stage.
- sample_valid  in  1  sample_in valid this cycle.
- sample_ready  out  1  block can accept a sample this cycle.
- dac_sync_n  out  1  DAC frame sync, active low.
- dac_sclk  out  1  DAC serial clock; idles high.
- dac_din  out  1  DAC serial data, MSB first.
- frame_done  out  1  one-cycle pulse when a frame completes.
- drop_cnt  out  8  saturating count of samples offered while not ready.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: sample_ready=1, dac_sync_n=1, dac_sclk=1. On sample_valid && sample_ready: latch shift word = {CMD, sample_in ^ (TWOS_COMP<<15)}, go to SHIFT.
- SHIFT: dac_sync_n=0, dac_din = current bit (starts at bit 23). A half-period counter counts 0..CLK_DIV-1; at terminal count dac_sclk toggles. A falling SCLK edge is the DAC capture point. On each rising SCLK edge (except the last), the shift word advances and dac_din presents the next bit. A bit counter counts falling edges 1..24.
- After the 24th falling edge plus one low half-period: dac_sclk returns high, dac_sync_n=1, frame_done=1 for that cycle, go to GAP.
- GAP: sample_ready=0 and lines idle for IDLE_CYC cycles, then go to IDLE.
- sample_in is ignored outside the accept cycle. Changes mid-frame do not affect the frame in flight.
- drop_cnt increments by 1 on every cycle with sample_valid=1 && sample_ready=0, and saturates at 255. It is never cleared except by reset.
- dac_din=0 whenever dac_sync_n=1.

## Timing
- Reset (async assert, sync release) values: state IDLE, sample_ready=1, dac_sync_n=1, dac_sclk=1, dac_din=0, frame_done=0, drop_cnt=0, all counters 0.
- Accept at rising edge k:
  - edge k+1: dac_sync_n=0, dac_sclk=1, dac_din=bit23.
- Falling SCLK edges occur at k+1+CLK_DIV*(2i+1), i=0..23. dac_din is stable from CLK_DIV cycles before each falling edge until CLK_DIV cycles after it.
- At k+1+48*CLK_DIV: dac_sync_n=1, dac_sclk=1, frame_done=1.
- At k+1+48*CLK_DIV+IDLE_CYC: sample_ready=1.
- Throughput: one sample per 48*CLK_DIV+IDLE_CYC+1 cycles (101 at defaults).
- Reset asserted mid-frame: outputs take reset values immediately (asynchronously) and the frame is aborted with no frame_done. After release, the block is in IDLE and ready.
- If sample_valid is high in the same cycle that GAP ends, it is not accepted (ready is still 0) and is counted in drop_cnt. Acceptance occurs on the following cycle if valid is held.
- All outputs are registered. No combinational path from sample_valid to sample_ready.

## Test plan
- Reset then send sample 16'h8000 at defaults -> dac_sync_n low for exactly 96 cycles; 24 falling SCLK edges; captured bits 0x00_8000; frame_done pulses once at cycle 97 after accept.
- TWOS_COMP=1, CMD=8'h10, samples 16'hFFFF and 16'h0000 back-to-back with valid held -> captured frames 0x10_7FFF then 0x10_8000; second accept occurs exactly 101 cycles after the first.
- CLK_DIV=1, IDLE_CYC=1, sample 16'hA5A5 -> SCLK period 2 cycles; sync low 48 cycles; captured 0x00_A5A5; ready returns 50 cycles after accept.
- Hold sample_valid high continuously for 300 cycles with sample_in stepping every cycle -> 3 frames carry only the values present on accept cycles; drop_cnt equals the number of non-ready valid cycles, saturating at 255 when extended.
- Assert rst_n low at cycle 40 of a frame -> dac_sync_n=1 and dac_sclk=1 within the same cycle; no frame_done. After release, a new sample 16'h1234 transmits as a complete, correct frame.
- Feed a full triangle period (the generator's output at default settings) -> the DAC model reconstructs the identical 16-bit sample sequence with no drops when the sample rate is ≤ 1/101 clk.
